// File: rtl/ram_if_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ram_if_pkg
// Purpose : Definitions shared by the RAM port arbiter slice. Holds the
//           arbiter FSM state type, the default RAM geometry and the SRAM
//           control-pin polarities.
// Ports   : none (package)
// Config  : none
// Rev     : 1.0 - initial release
// ============================================================================
package ram_if_pkg;

  localparam int RAM_ADDR_W = 5;
  localparam int RAM_DATA_W = 32;

  // SRAM control pins are active-low
  localparam logic RAM_CEN_ON  = 1'b0;
  localparam logic RAM_CEN_OFF = 1'b1;
  localparam logic RAM_WEN_WR  = 1'b0;
  localparam logic RAM_WEN_RD  = 1'b1;

  typedef enum logic [1:0] {
    ST_CORE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_WB    = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/ram_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module  : ram_rd_pipe
// Purpose : Tracks SRAM reads in flight. An RD_LAT-deep valid/owner shift
//           register marks the cycle in which ram_q_i carries the data of
//           each issued read and steers it either to the core read-data
//           register (with a one-cycle rvalid pulse) or to the WB result
//           register.
// Ports   : wb_clk_i, wb_rst_i   clock / async active-high reset
//           i_issue, i_issue_wb  read issued this cycle, and its owner
//           i_ram_q              SRAM read data
//           o_core_rvalid/rdata  core read return
//           o_wb_rdata           last WB read result
//           o_core_inflight      a core read is still in the shift register
// Config  : none
// Rev     : 1.0 - initial release
// ============================================================================
module ram_rd_pipe #(
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              i_issue,
  input  logic              i_issue_wb,
  input  logic [DATA_W-1:0] i_ram_q,
  output logic              o_core_rvalid,
  output logic [DATA_W-1:0] o_core_rdata,
  output logic [DATA_W-1:0] o_wb_rdata,
  output logic              o_core_inflight
);

  logic [RD_LAT-1:0] r_vld;
  logic [RD_LAT-1:0] r_own;
  logic              r_core_rvalid;
  logic [DATA_W-1:0] r_core_rdata;
  logic [DATA_W-1:0] r_wb_rdata;

  // The last stage marks the cycle in which ram_q_i belongs to that read
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_vld         <= '0;
      r_own         <= '0;
      r_core_rvalid <= 1'b0;
      r_core_rdata  <= '0;
      r_wb_rdata    <= '0;
    end else begin
      r_vld[0] <= i_issue;
      r_own[0] <= i_issue_wb;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_own[i] <= r_own[i-1];
      end
      r_core_rvalid <= r_vld[RD_LAT-1] & ~r_own[RD_LAT-1];
      if (r_vld[RD_LAT-1] && !r_own[RD_LAT-1]) begin
        r_core_rdata <= i_ram_q;
      end
      if (r_vld[RD_LAT-1] && r_own[RD_LAT-1]) begin
        r_wb_rdata <= i_ram_q;
      end
    end
  end

  assign o_core_rvalid   = r_core_rvalid;
  assign o_core_rdata    = r_core_rdata;
  assign o_wb_rdata      = r_wb_rdata;
  assign o_core_inflight = |(r_vld & ~r_own);

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ram_port_arbiter
// Purpose : Owns the single port of the 32x32 SRAM and shares it between the
//           Wishbone RAM control registers and the user core. Level-style WB
//           register contents become one-cycle SRAM writes (only when the
//           written value changes) or a continuous read poll. The core is
//           stalled while WB owns the RAM.
// Ports   : wb_clk_i / wb_rst_i          clock / async active-high reset
//           ram_wb_*                     WB register side (level inputs)
//           ram_wb_data_from_ram         last WB read result
//           core_req/we/addr/wdata_i     core request
//           core_gnt/rvalid/rdata_o      core handshake and read return
//           ram_cen/wen/a/d_o, ram_q_i   SRAM macro pins
//           wb_owner_o                   WB side currently owns the RAM
// Config  : RAM_ARB_STATS_EN adds wb_wr_count_o / core_acc_count_o,
//           saturating 16-bit counts of WB writes and core grants.
// Rev     : 1.0 - initial release
// ============================================================================
module ram_port_arbiter
  import ram_if_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              ram_wb_active,
  input  logic              ram_wb_we_i,
  input  logic [ADDR_W-1:0] ram_wb_addr,
  input  logic [DATA_W-1:0] ram_wb_data_to_ram,
  output logic [DATA_W-1:0] ram_wb_data_from_ram,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  output logic [DATA_W-1:0] core_rdata_o,
  output logic              ram_cen_o,
  output logic              ram_wen_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic [DATA_W-1:0] ram_d_o,
  input  logic [DATA_W-1:0] ram_q_i,
  output logic              wb_owner_o
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [15:0]       wb_wr_count_o,
  output logic [15:0]       core_acc_count_o
`endif
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              w_gnt;
  logic              w_cen;
  logic              w_wen;
  logic [ADDR_W-1:0] w_a;
  logic [DATA_W-1:0] w_d;
  logic              w_issue;
  logic              w_issue_wb;
  logic              w_wb_wr;
  logic              w_core_inflight;
  logic              w_wb_change;

  // Snapshot of the last {addr,data} seen in WB write mode. r_snap_vld is
  // low on WB entry and after a we=0 cycle, so those cycles always write.
  logic              r_snap_vld;
  logic [ADDR_W-1:0] r_snap_addr;
  logic [DATA_W-1:0] r_snap_data;

  assign w_wb_change = ~r_snap_vld
                     | (ram_wb_addr != r_snap_addr)
                     | (ram_wb_data_to_ram != r_snap_data);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= ST_CORE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // SRAM pins are driven combinationally so a grant hits the macro in the
  // same cycle; reset forces every pin to its idle value.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt       = 1'b0;
    w_cen       = RAM_CEN_OFF;
    w_wen       = RAM_WEN_RD;
    w_a         = '0;
    w_d         = '0;
    w_issue     = 1'b0;
    w_issue_wb  = 1'b0;
    w_wb_wr     = 1'b0;
    if (!wb_rst_i) begin
      case (r_state)
        ST_CORE: begin
          if (ram_wb_active) begin
            w_state_nxt = w_core_inflight ? ST_DRAIN : ST_WB;
          end else if (core_req_i) begin
            w_gnt   = 1'b1;
            w_cen   = RAM_CEN_ON;
            w_wen   = core_we_i ? RAM_WEN_WR : RAM_WEN_RD;
            w_a     = core_addr_i;
            w_d     = core_we_i ? core_wdata_i : '0;
            w_issue = ~core_we_i;
          end
        end
        ST_DRAIN: begin
          if (!w_core_inflight) begin
            w_state_nxt = ST_WB;
          end
        end
        ST_WB: begin
          // Exit cycle performs no access, so a change seen here is dropped
          if (!ram_wb_active) begin
            w_state_nxt = ST_CORE;
          end else if (!ram_wb_we_i) begin
            w_cen      = RAM_CEN_ON;
            w_a        = ram_wb_addr;
            w_issue    = 1'b1;
            w_issue_wb = 1'b1;
          end else if (w_wb_change) begin
            w_cen   = RAM_CEN_ON;
            w_wen   = RAM_WEN_WR;
            w_a     = ram_wb_addr;
            w_d     = ram_wb_data_to_ram;
            w_wb_wr = 1'b1;
          end
        end
        default: w_state_nxt = ST_CORE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_snap_vld  <= 1'b0;
      r_snap_addr <= '0;
      r_snap_data <= '0;
    end else if (r_state == ST_WB && ram_wb_active && ram_wb_we_i) begin
      r_snap_vld  <= 1'b1;
      r_snap_addr <= ram_wb_addr;
      r_snap_data <= ram_wb_data_to_ram;
    end else begin
      r_snap_vld  <= 1'b0;
    end
  end

  ram_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .wb_clk_i        (wb_clk_i),
    .wb_rst_i        (wb_rst_i),
    .i_issue         (w_issue),
    .i_issue_wb      (w_issue_wb),
    .i_ram_q         (ram_q_i),
    .o_core_rvalid   (core_rvalid_o),
    .o_core_rdata    (core_rdata_o),
    .o_wb_rdata      (ram_wb_data_from_ram),
    .o_core_inflight (w_core_inflight)
  );

  assign core_gnt_o = w_gnt;
  assign ram_cen_o  = w_cen;
  assign ram_wen_o  = w_wen;
  assign ram_a_o    = w_a;
  assign ram_d_o    = w_d;
  assign wb_owner_o = (r_state == ST_WB);

`ifdef RAM_ARB_STATS_EN
  logic [15:0] r_wb_wr_count;
  logic [15:0] r_core_acc_count;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_wb_wr_count    <= '0;
      r_core_acc_count <= '0;
    end else begin
      if (w_wb_wr && r_wb_wr_count != 16'hFFFF) begin
        r_wb_wr_count <= r_wb_wr_count + 16'd1;
      end
      if (w_gnt && r_core_acc_count != 16'hFFFF) begin
        r_core_acc_count <= r_core_acc_count + 16'd1;
      end
    end
  end

  assign wb_wr_count_o    = r_wb_wr_count;
  assign core_acc_count_o = r_core_acc_count;
`endif

endmodule
`default_nettype wire
